// File: rtl/boot_rom_pkg.sv
// Shared definitions for the boot ROM arbiter.
//   ROM_DEPTH / ROM_AW : default ROM geometry (valid words, word-address width)
//   port_e             : requester identity (instruction fetch or data/debug)
//   resp_t             : response pipeline slot (valid, owner, err)
//   resp_state_e       : response pipeline FSM states
package boot_rom_pkg;

  localparam int ROM_DEPTH = 548;
  localparam int ROM_AW    = 10;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e owner;
    logic  err;
  } resp_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } resp_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with combinational grant.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_req_instr   : request from the instruction port
//   i_req_data    : request from the data port
//   o_gnt_instr   : grant to the instruction port (same cycle as request)
//   o_gnt_data    : grant to the data port (same cycle as request)
// On a tie the port that did not win the most recent grant wins. The
// history resets to DATA so the instruction port wins the first tie.
module rr_arb2
  import boot_rom_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_instr,
  input  logic i_req_data,
  output logic o_gnt_instr,
  output logic o_gnt_data
);

  port_e r_last_grant;
  logic  w_prefer_instr;

  assign w_prefer_instr = (r_last_grant == PORT_DATA);
  assign o_gnt_instr    = i_req_instr & (~i_req_data | w_prefer_instr);
  assign o_gnt_data     = i_req_data  & (~i_req_instr | ~w_prefer_instr);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= PORT_DATA;
    end else if (o_gnt_instr) begin
      r_last_grant <= PORT_INSTR;
    end else if (o_gnt_data) begin
      r_last_grant <= PORT_DATA;
    end
  end

endmodule

// File: rtl/boot_rom_arbiter.sv
// Shares a single-port, registered-address boot ROM between the core
// instruction-fetch port and the data/debug port.
//   CLK, RSTN              : clock, asynchronous active-low reset
//   instr_req_i/addr_i     : instruction fetch request, byte address
//   instr_gnt_o            : request accepted this cycle
//   instr_rvalid/rdata/err : response one cycle after the grant
//   data_req_i/addr_i/we_i : data/debug request; writes are always errors
//   data_gnt_o             : request accepted this cycle
//   data_rvalid/rdata/err  : response one cycle after the grant
//   rom_csn_o, rom_addr_o  : ROM chip select (active low) and word address
//   rom_rdata_i            : ROM data, valid the cycle after CSN was low
// Out-of-range reads and writes never touch the ROM; they return err with
// zero data. Address bits above the word index are ignored.
module boot_rom_arbiter
  import boot_rom_pkg::port_e, boot_rom_pkg::PORT_INSTR, boot_rom_pkg::PORT_DATA,
         boot_rom_pkg::resp_t, boot_rom_pkg::resp_state_e,
         boot_rom_pkg::ST_IDLE, boot_rom_pkg::ST_RESP;
#(
  parameter int ROM_DEPTH = boot_rom_pkg::ROM_DEPTH,
  parameter int ROM_AW    = boot_rom_pkg::ROM_AW,
  parameter int DATA_W    = 32
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              instr_req_i,
  input  logic [31:0]       instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [DATA_W-1:0] instr_rdata_o,
  output logic              instr_err_o,
  input  logic              data_req_i,
  input  logic [31:0]       data_addr_i,
  input  logic              data_we_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_err_o,
  output logic              rom_csn_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_rdata_i
);

  logic              w_gnt_instr;
  logic              w_gnt_data;
  logic              w_any_gnt;
  port_e             w_gnt_owner;
  logic [ROM_AW-1:0] w_idx;
  logic              w_err;
  logic              w_rom_en;

  resp_state_e r_state;
  resp_state_e w_state_nxt;
  port_e       r_owner;
  logic        r_err;
  resp_t       w_resp;

  // Only the word index is decoded; the rest belongs to the interconnect.
  logic w_unused_addr;
  assign w_unused_addr = ^{instr_addr_i[31:ROM_AW+2], instr_addr_i[1:0],
                           data_addr_i[31:ROM_AW+2], data_addr_i[1:0]};

  rr_arb2 u_arb (
    .clk         (CLK),
    .rst_n       (RSTN),
    .i_req_instr (instr_req_i),
    .i_req_data  (data_req_i),
    .o_gnt_instr (w_gnt_instr),
    .o_gnt_data  (w_gnt_data)
  );

  assign instr_gnt_o = w_gnt_instr;
  assign data_gnt_o  = w_gnt_data;

  // Classify the granted access in the request cycle.
  // NOTE: every variable written in always_comb gets a value before any
  // branch, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_any_gnt   = w_gnt_instr | w_gnt_data;
    w_gnt_owner = w_gnt_data ? PORT_DATA : PORT_INSTR;
    w_idx       = w_gnt_data ? data_addr_i[ROM_AW+1:2] : instr_addr_i[ROM_AW+1:2];
    w_err       = (w_gnt_data & data_we_i) | (32'(w_idx) >= ROM_DEPTH);
    w_rom_en    = w_any_gnt & ~w_err;
  end

  assign rom_csn_o  = ~w_rom_en;
  assign rom_addr_o = w_rom_en ? w_idx : '0;

  // Response pipeline: RESP means a response is due in the current cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any_gnt)  w_state_nxt = ST_RESP;
      ST_RESP: if (!w_any_gnt) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= ST_IDLE;
      r_owner <= PORT_INSTR;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_any_gnt) begin
        r_owner <= w_gnt_owner;
        r_err   <= w_err;
      end
    end
  end

  always_comb begin
    w_resp.valid = (r_state == ST_RESP);
    w_resp.owner = r_owner;
    w_resp.err   = r_err;
  end

  // Data is forced to zero unless the response is a successful read.
  always_comb begin
    instr_rvalid_o = w_resp.valid & (w_resp.owner == PORT_INSTR);
    data_rvalid_o  = w_resp.valid & (w_resp.owner == PORT_DATA);
    instr_err_o    = instr_rvalid_o & w_resp.err;
    data_err_o     = data_rvalid_o & w_resp.err;
    instr_rdata_o  = (instr_rvalid_o & ~w_resp.err) ? rom_rdata_i : '0;
    data_rdata_o   = (data_rvalid_o & ~w_resp.err) ? rom_rdata_i : '0;
  end

endmodule

// File: doc/boot_rom_arbiter.md
Name: boot_rom_arbiter

Overview:
- Shares the single-port, registered-address boot ROM between two requesters: the core instruction-fetch port and the data/debug port.
- Sits between the core/debug interconnect and the boot ROM.
- Arbitrates round-robin, drives the ROM chip-select and word address, and routes the one-cycle-later ROM data back to the granted requester.
- Flags errors for out-of-range and write accesses.

Parameters:
- ROM_DEPTH, 548, number of valid 32-bit ROM words; word index >= ROM_DEPTH is out-of-range.
- ROM_AW, 10, ROM word-address width.
- DATA_W, 32, ROM and bus data width.

Ports:
- CLK  input  1  clock
- RSTN  input  1  asynchronous active-low reset
- instr_req_i  input  1  instruction fetch request
- instr_addr_i  input  32  byte address; bits [ROM_AW+1:2] form the word index
- instr_gnt_o  output  1  request accepted this cycle
- instr_rvalid_o  output  1  response valid
- instr_rdata_o  output  DATA_W  response data
- instr_err_o  output  1  response error
- data_req_i  input  1  data/debug request
- data_addr_i  input  32  byte address
- data_we_i  input  1  write enable; writes are illegal
- data_gnt_o  output  1  request accepted this cycle
- data_rvalid_o  output  1  response valid
- data_rdata_o  output  DATA_W  response data
- data_err_o  output  1  response error
- rom_csn_o  output  1  ROM chip select, active low
- rom_addr_o  output  ROM_AW  ROM word address
- rom_rdata_i  input  DATA_W  ROM data, valid the cycle after the CSN-low edge

Behaviour:
- Clock and reset: one clock CLK; RSTN asynchronous, active-low.
- Reset values:
  - all gnt, rvalid and err outputs 0; rdata outputs 0.
  - rom_csn_o 1; rom_addr_o 0.
  - internal last_grant = DATA, so instr wins the first tie.
- Grant is combinational in the request cycle N:
  - at most one gnt per cycle.
  - single requester: granted immediately.
  - both requesting: grant the port not equal to last_grant; last_grant updates on every grant.
- The ROM is fixed-latency with no backpressure, so a grant is possible every cycle, including back-to-back. Request inputs must be held until gnt.
- Classification of the granted access in cycle N:
  - read with index < ROM_DEPTH: rom_csn_o = 0, rom_addr_o = index.
  - read with index >= ROM_DEPTH: rom_csn_o = 1 (no ROM access).
  - write (data_we_i = 1): rom_csn_o = 1 (no ROM access).
  - rom_csn_o is 1 in any cycle without a grant.
- Registered response state (resp_valid, resp_owner, resp_err) is captured at the edge closing cycle N.
- Response in cycle N+1, on the owner's port only:
  - rvalid = 1.
  - rdata = rom_rdata_i on success, 0 on error.
  - err = 1 for out-of-range or write.
  - the other port's rvalid = 0.
- rdata outputs are 0 whenever their rvalid is 0.
- Response overlap: a response in N+1 and a new grant in N+1 may coexist; the grant produces its response in N+2.
- Bits of the address above ROM_AW+1 are ignored; region decode belongs to the interconnect.
- Reset mid-transaction: the pending response is dropped (no rvalid after RSTN deasserts) and last_grant returns to DATA.
- Internal FSM (resp pipeline): IDLE -> RESP when a grant occurs; RESP -> RESP on a back-to-back grant; RESP -> IDLE with no grant.

Decomposition:
- Shared package boot_rom_pkg holds:
  - ROM_DEPTH and ROM_AW constants.
  - typedef enum port_e {PORT_INSTR, PORT_DATA}.
  - typedef struct resp_t {valid, owner, err}.
- Sub-module rr_arb2: 2-way round-robin arbiter with last_grant register, combinational gnt. It is reusable elsewhere.
- The top module holds the decode, ROM drive and response routing.

Test Plan:
- Reset then instr read addr 0x0000_0080 -> instr_gnt_o = 1 same cycle, rom_csn_o = 0, rom_addr_o = 0x20; next cycle instr_rvalid_o = 1, instr_rdata_o = ROM[32], err = 0.
- Both ports request continuously for 6 cycles (instr 0x0, data 0x4) -> grants alternate I, D, I, D, I, D; each rvalid one cycle after its gnt on the correct port with correct data.
- Data read addr 0x0000_0890 (index 548) -> data_gnt_o = 1, rom_csn_o = 1; next cycle data_rvalid_o = 1, data_err_o = 1, data_rdata_o = 0.
- Data write addr 0x10, we = 1 -> granted, no ROM access, data_err_o = 1 next cycle; ROM content unaffected on a later read of 0x10.
- Instr back-to-back reads 0x0, 0x4, 0x8 -> three consecutive gnt cycles, rvalid high three consecutive cycles with ROM[0], ROM[1], ROM[2].
- Grant in cycle N, RSTN pulsed low mid-cycle N -> no rvalid in N+1; first tie after reset goes to instr.
